uart_mem_loader: RTL and testbench

- Sits directly downstream of the UART receiver in uart_system.
- Consumes the receiver's byte stream (byteFromRx / rx_new_byte_indicate) and assembles little-endian memory words from it.
- Writes the words to consecutive addresses of an instruction/data memory, so the host can load processor memories over the serial link before the cores start.
- Reports busy/done to the top-level controller.

---
 rtl/uart_mem_loader.sv | 188 ++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_loader
// Description : Takes the byte stream from the UART receiver, packs it into
//               little-endian memory words (first byte = LSB) and writes
//               the words to consecutive memory addresses. The host uses it
//               to load processor memories over the serial link before the
//               cores are released.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH : UART byte width
//   MEM_WIDTH  : memory word width, an integer multiple of DATA_WIDTH
//   ADDR_WIDTH : memory address width
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle pulse that begins a load (ignored while busy)
//   startAddr   in   first write address, latched on start
//   wordCount   in   number of words to load, latched on start
//   rxByte      in   byte from the UART receiver
//   rxByteValid in   one-cycle strobe qualifying rxByte
//   memWrEn     out  one-cycle memory write strobe
//   memAddr     out  write address (held between writes)
//   memWrData   out  write data (held between writes)
//   busy        out  high while words are being received
//   done        out  high once the load has finished, until the next start
// ============================================================================
module uart_mem_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_WIDTH  = 24,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  input  logic [ADDR_WIDTH-1:0] wordCount,
  input  logic [DATA_WIDTH-1:0] rxByte,
  input  logic                  rxByteValid,
  output logic                  memWrEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [MEM_WIDTH-1:0]  memWrData,
  output logic                  busy,
  output logic                  done
);

  localparam int BYTES_PER_WORD = MEM_WIDTH / DATA_WIDTH;
  // A one-byte word still needs a 1-bit index register.
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [IDX_W-1:0]      c_LAST_BYTE_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE      = ADDR_WIDTH'(1);

  localparam logic [1:0] c_S_IDLE    = 2'd0;
  localparam logic [1:0] c_S_RECEIVE = 2'd1;
  localparam logic [1:0] c_S_DONE    = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;

  logic [ADDR_WIDTH-1:0] r_base_addr;
  logic [ADDR_WIDTH-1:0] r_word_count;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [IDX_W-1:0]      r_byte_idx;
  logic [MEM_WIDTH-1:0]  r_assembly;

  logic                  r_mem_wr_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [MEM_WIDTH-1:0]  r_mem_wr_data;

  logic                  w_start_accept;
  logic                  w_byte_take;
  logic                  w_word_complete;
  logic                  w_final_word;
  logic [MEM_WIDTH-1:0]  w_assembled;
  logic                  w_busy;
  logic                  w_done;

  // start is only honoured outside RECEIVE; bytes only inside it. In IDLE a
  // simultaneous byte is therefore dropped in favour of start.
  assign w_start_accept  = start && (r_state != c_S_RECEIVE);
  assign w_byte_take     = rxByteValid && (r_state == c_S_RECEIVE);
  assign w_word_complete = w_byte_take && (r_byte_idx == c_LAST_BYTE_IDX);
  assign w_final_word    = (r_word_idx == (r_word_count - c_ADDR_ONE));

  // Assembly register with the current byte already merged in, so the word
  // written on the last byte includes that byte.
  always_comb begin
    w_assembled = r_assembly;
    w_assembled[int'(r_byte_idx) * DATA_WIDTH +: DATA_WIDTH] = rxByte;
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE, c_S_DONE: begin
        if (start) begin
          // A zero-length load finishes immediately without any write.
          w_next_state = (wordCount == '0) ? c_S_DONE : c_S_RECEIVE;
        end
      end
      c_S_RECEIVE: begin
        // Leave on the same edge that launches the last write, so done rises
        // together with the final memWrEn pulse.
        if (w_word_complete && w_final_word) begin
          w_next_state = c_S_DONE;
        end
      end
      default: w_next_state = c_S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      c_S_RECEIVE: w_busy = 1'b1;
      c_S_DONE:    w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: load context, byte assembly and write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base_addr   <= '0;
      r_word_count  <= '0;
      r_word_idx    <= '0;
      r_byte_idx    <= '0;
      r_assembly    <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
    end else begin
      r_mem_wr_en <= 1'b0;
      if (w_start_accept) begin
        r_base_addr  <= startAddr;
        r_word_count <= wordCount;
        r_word_idx   <= '0;
        r_byte_idx   <= '0;
        r_assembly   <= '0;
      end else if (w_byte_take) begin
        r_assembly <= w_assembled;
        if (w_word_complete) begin
          r_mem_wr_en   <= 1'b1;
          r_mem_wr_data <= w_assembled;
          // Address arithmetic wraps naturally at the address width.
          r_mem_addr    <= r_base_addr + r_word_idx;
          r_byte_idx    <= '0;
          r_word_idx    <= r_word_idx + c_ADDR_ONE;
        end else begin
          r_byte_idx <= r_byte_idx + IDX_W'(1);
        end
      end
    end
  end

  assign memWrEn   = r_mem_wr_en;
  assign memAddr   = r_mem_addr;
  assign memWrData = r_mem_wr_data;
  assign busy      = w_busy;
  assign done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mem_loader
// Description : Self-checking bench for uart_mem_loader. Drivers push the
//               expected writes into a scoreboard queue; a monitor pops and
//               compares whenever memWrEn is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mem_loader;

  localparam int DW  = 8;
  localparam int MW  = 24;
  localparam int AW  = 12;
  localparam int BPW = MW / DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] startAddr;
  logic [AW-1:0] wordCount;
  logic [DW-1:0] rxByte;
  logic          rxByteValid;
  logic          memWrEn;
  logic [AW-1:0] memAddr;
  logic [MW-1:0] memWrData;
  logic          busy;
  logic          done;

  uart_mem_loader #(
    .DATA_WIDTH(DW),
    .MEM_WIDTH (MW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .startAddr  (startAddr),
    .wordCount  (wordCount),
    .rxByte     (rxByte),
    .rxByteValid(rxByteValid),
    .memWrEn    (memWrEn),
    .memAddr    (memAddr),
    .memWrData  (memWrData),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [MW-1:0] d;
    int            c;
    bit            last;
  } exp_t;

  exp_t          sb[$];
  logic [7:0]    pat[$];
  logic [AW-1:0] exp_last_a = '0;
  logic [MW-1:0] exp_last_d = '0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write,
  // including the cycle it appears in and the done/busy flags alongside it.
  always @(negedge clk) begin
    if (memWrEn !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required=no write (cycle %0d)",
                 memAddr, memWrData, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr",  64'(memAddr),   64'(e.a));
        chk("wr_data",  64'(memWrData), 64'(e.d));
        chk("wr_cycle", 64'(cyc),       64'(e.c));
        chk("wr_done",  64'(done),      64'(e.last));
        chk("wr_busy",  64'(busy),      64'(!e.last));
      end
    end
  end

  // Run one load. gap < 0 picks a random 0..3 idle cycles after each byte.
  // noise adds ignored stimulus: a byte with the start pulse and spurious
  // start pulses while the load is in progress.
  task automatic do_load(input logic [AW-1:0] sa, input int wc, input int gap, input bit noise);
    logic [MW-1:0] word;
    int            g;
    while (pat.size() < wc * BPW) pat.push_back(8'($urandom_range(0, 255)));
    @(posedge clk); #1;
    start     = 1'b1;
    startAddr = sa;
    wordCount = AW'(wc);
    if (noise && ($urandom_range(0, 1) == 1)) begin
      rxByteValid = 1'b1;
      rxByte      = 8'hEE;
    end
    @(posedge clk); #1;
    start       = 1'b0;
    rxByteValid = 1'b0;
    startAddr   = AW'($urandom);
    wordCount   = AW'($urandom);
    chk("start_busy", 64'(busy), 64'(wc != 0));
    chk("start_done", 64'(done), 64'(wc == 0));
    for (int w = 0; w < wc; w++) begin
      word = '0;
      for (int k = 0; k < BPW; k++) begin
        word        = word | (MW'(pat[w*BPW+k]) << (DW * k));
        rxByte      = pat[w*BPW+k];
        rxByteValid = 1'b1;
        if (k == BPW - 1) begin
          sb.push_back('{a: AW'(int'(sa) + w), d: word, c: cyc + 1, last: (w == wc - 1)});
          exp_last_a = AW'(int'(sa) + w);
          exp_last_d = word;
        end
        @(posedge clk); #1;
        rxByteValid = 1'b0;
        rxByte      = DW'($urandom);
        g = (gap < 0) ? $urandom_range(0, 3) : gap;
        for (int i = 0; i < g; i++) begin
          if (noise && !(w == wc - 1 && k == BPW - 1) && ($urandom_range(0, 3) == 0))
            start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("end_done",   64'(done),      64'd1);
    chk("end_busy",   64'(busy),      64'd0);
    chk("hold_addr",  64'(memAddr),   64'(exp_last_a));
    chk("hold_data",  64'(memWrData), 64'(exp_last_d));
    pat.delete();
  endtask

  // Bytes presented outside RECEIVE must have no effect.
  task automatic stray_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rxByteValid = 1'b1;
      rxByte      = (i == 0) ? 8'hAA : (i == 1) ? 8'hBB : DW'($urandom);
    end
    @(posedge clk); #1;
    rxByteValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] ra;
    int            rw;
    rst         = 1'b1;
    start       = 1'b0;
    startAddr   = '0;
    wordCount   = '0;
    rxByte      = '0;
    rxByteValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_wren", 64'(memWrEn),   64'd0);
    chk("rst_addr", 64'(memAddr),   64'd0);
    chk("rst_data", 64'(memWrData), 64'd0);
    chk("rst_busy", 64'(busy),      64'd0);
    chk("rst_done", 64'(done),      64'd0);

    // Stray bytes in IDLE, then a single-word load.
    stray_bytes(2);
    chk("idle_done", 64'(done), 64'd0);
    pat = '{8'h01, 8'h02, 8'h03};
    do_load(12'h100, 1, 1, 1'b0);

    // Two words, bytes spaced 5 clocks apart, then back-to-back.
    pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_load(12'h010, 2, 4, 1'b0);
    pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_load(12'h010, 2, 0, 1'b0);

    // Zero-length load.
    do_load(12'h2AB, 0, 0, 1'b0);

    // Address wrap at the top of memory.
    pat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_load(12'hFFF, 2, 0, 1'b0);

    // Stray bytes while in DONE.
    stray_bytes(4);
    chk("stray_done_held", 64'(done), 64'd1);

    // Abort a 3-word load after 4 bytes with reset.
    @(posedge clk); #1;
    start     = 1'b1;
    startAddr = 12'h050;
    wordCount = 12'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rxByte      = 8'hC0 + 8'(k);
      rxByteValid = 1'b1;
      if (k == 2) sb.push_back('{a: 12'h050, d: 24'hC2C1C0, c: cyc + 1, last: 1'b0});
      @(posedge clk); #1;
    end
    rxByteValid = 1'b0;
    rst         = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_wren", 64'(memWrEn),   64'd0);
    chk("abort_addr", 64'(memAddr),   64'd0);
    chk("abort_data", 64'(memWrData), 64'd0);
    chk("abort_busy", 64'(busy),      64'd0);
    chk("abort_done", 64'(done),      64'd0);
    exp_last_a = '0;
    exp_last_d = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_sb", 64'(sb.size()), 64'd0);
    pat = '{8'h07, 8'h08, 8'h09};
    do_load(12'h020, 1, 0, 1'b0);

    // Randomized loads with ignored-stimulus noise.
    for (int n = 0; n < 30; n++) begin
      ra = AW'($urandom);
      rw = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) stray_bytes($urandom_range(1, 3));
      do_load(ra, rw, -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
